// File: rtl/acumulador_seq.sv
// acumulador_seq: frame sequencer that feeds operands and clear/load/transf controls to the accumulator.
// Optional overflow tracking is built when SEQ_OVF_EN is defined; otherwise ovf is tied low.
module acumulador_seq #(
    parameter int W  = 16,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [LW-1:0] len,
    input  logic          op_valid,
    input  logic [W-1:0]  op_data,
    output logic          op_ready,
    output logic [W-1:0]  acc_in,
    output logic          acc_load,
    output logic          acc_transf,
    output logic          acc_clear_n,
    output logic          busy,
    output logic          done,
    output logic          ovf
);
    typedef enum logic [2:0] {IDLE, CLR, FEED, DRAIN, XFER} state_t;

    state_t        state, state_nxt;
    logic [LW-1:0] len_q, count;
    logic          hs;

    assign op_ready = state == FEED;
    assign hs       = op_valid && op_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? CLR : IDLE;
            CLR:     state_nxt = len_q != '0 ? FEED : DRAIN;
            FEED:    state_nxt = hs && count + LW'(1) == len_q ? DRAIN : FEED;
            DRAIN:   state_nxt = XFER;
            XFER:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the upcoming state so each lands in its own cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            len_q       <= '0;
            count       <= '0;
            acc_in      <= '0;
            acc_load    <= 1'b0;
            acc_transf  <= 1'b0;
            acc_clear_n <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            len_q       <= state == IDLE && start ? len : len_q;
            count       <= state_nxt == CLR ? '0 : hs ? count + LW'(1) : count;
            acc_in      <= hs ? op_data : acc_in;
            acc_load    <= hs;
            acc_transf  <= state_nxt == XFER;
            acc_clear_n <= state_nxt != CLR;
            busy        <= state_nxt != IDLE;
            done        <= state == XFER;
        end
    end

`ifdef SEQ_OVF_EN
    logic [W:0] shadow, shadow_sum;

    assign shadow_sum = shadow + {1'b0, op_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
            ovf    <= 1'b0;
        end else if (state_nxt == CLR) begin
            shadow <= '0;
            ovf    <= 1'b0;
        end else if (hs) begin
            shadow <= shadow_sum;
            ovf    <= ovf | shadow_sum[W];
        end
    end
`else
    assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_acumulador_seq.sv
// tb_acumulador_seq: randomized scoreboard bench; a monitor checks load/clear/transf/done timing
// and the resulting accumulator value against expectations pushed by the driver.
module tb_acumulador_seq;
    localparam int W  = 16;
    localparam int LW = 8;
`ifdef SEQ_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, start, op_valid;
    logic [LW-1:0] len;
    logic [W-1:0]  op_data;
    logic          op_ready, acc_load, acc_transf, acc_clear_n, busy, done, ovf;
    logic [W-1:0]  acc_in;

    acumulador_seq #(.W(W), .LW(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready),
        .acc_in(acc_in), .acc_load(acc_load), .acc_transf(acc_transf),
        .acc_clear_n(acc_clear_n), .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {int c; logic [W-1:0] d;} ld_t;
    typedef struct {int tc; int dc; logic [W-1:0] sum; logic ovf;} fr_t;

    ld_t          load_q[$];
    fr_t          frame_q[$];
    int           clr_q[$];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] acc_sum = '0;
    logic [W-1:0] acc_out = '0;
    logic [W-1:0] ops[8];
    ld_t          le;
    fr_t          fe;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic ovf_exp(input int tot);
        return OVF_ON && tot >= 65536;
    endfunction

    // Monitor: scoreboard checks plus a plain behavioural accumulator fed by the DUT controls.
    always @(negedge clk) begin
        if (!rst) begin
            if (!acc_clear_n) begin
                if (clr_q.size() == 0) chk("unexpected_clear", 1, 0);
                else chk("clear_cyc", cyc, clr_q.pop_front());
            end
            if (acc_load) begin
                if (load_q.size() == 0) chk("unexpected_load", 1, 0);
                else begin
                    le = load_q.pop_front();
                    chk("load_cyc", cyc, le.c);
                    chk("load_data", acc_in, le.d);
                end
            end
            if (acc_transf) begin
                if (frame_q.size() == 0) chk("unexpected_transf", 1, 0);
                else chk("transf_cyc", cyc, frame_q[0].tc);
            end
            if (done) begin
                if (frame_q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    fe = frame_q.pop_front();
                    chk("done_cyc", cyc, fe.dc);
                    chk("acc_out", acc_out, fe.sum);
                    chk("ovf_at_done", ovf, fe.ovf);
                    chk("busy_at_done", busy, 0);
                end
            end
        end
        if (!acc_clear_n) acc_sum = '0;
        else if (acc_load) acc_sum = acc_sum + acc_in;
        if (acc_transf) acc_out = acc_sum;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // gap < 0 picks a random idle gap after each accepted operand; abort_at > 0 resets mid-frame.
    task automatic frame(input int n, input int gap, input bit sfeed, input bit sdone, input int abort_at);
        int s, got, tot, t, off, k;
        t = 0;
        while (busy && t < 50) begin step(); t++; end
        start = 1'b1;
        len = LW'(n);
        s = cyc + 1;
        clr_q.push_back(s);
        step();
        start = 1'b0;
        tot = 0;
        got = 0;
        off = 0;
        t = 0;
        if (n == 0) frame_q.push_back('{s + 2, s + 3, '0, 1'b0});
        while (got < n && t < 200) begin
            op_valid = off == 0;
            op_data  = op_valid ? ops[got] : W'($urandom);
            start    = sfeed && op_ready && !op_valid;
            if (op_valid && op_ready) begin
                k = cyc + 1;
                load_q.push_back('{k, ops[got]});
                tot += int'(ops[got]);
                got++;
                if (got == n) frame_q.push_back('{k + 1, k + 2, tot[W-1:0], ovf_exp(tot)});
                off = gap < 0 ? int'($urandom_range(0, 2)) : gap;
            end else if (off > 0) off--;
            step();
            t++;
            if (abort_at != 0 && got == abort_at) break;
        end
        start = 1'b0;
        if (t >= 200) chk("feed_timeout", 0, 1);
        if (abort_at != 0) begin
            op_valid = 1'b0;
            rst = 1'b1;
            #1;
            chk("abort_clear_n", acc_clear_n, 0);
            chk("abort_busy", busy, 0);
            chk("abort_load", acc_load, 0);
            chk("abort_ready", op_ready, 0);
            chk("abort_done", done, 0);
            load_q.delete();
            frame_q.delete();
            clr_q.delete();
            repeat (2) step();
            rst = 1'b0;
            step();
            return;
        end
        op_valid = 1'b1;
        op_data  = 16'hBEEF;
        t = 0;
        while (frame_q.size() != 0 && t < 20) begin
            start = sdone && acc_transf;
            step();
            t++;
        end
        start = 1'b0;
        op_valid = 1'b0;
        if (t >= 20) chk("done_timeout", 0, 1);
        repeat (3) begin
            step();
            chk("idle_busy", busy, 0);
            chk("idle_clear_n", acc_clear_n, 1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        len = '0;
        op_valid = 1'b0;
        op_data = '0;
        #2;
        chk("rst_clear_n", acc_clear_n, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", op_ready, 0);
        chk("rst_load", acc_load, 0);
        chk("rst_transf", acc_transf, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_acc_in", acc_in, 0);
        repeat (2) step();
        rst = 1'b0;
        step();
        chk("rel_clear_n", acc_clear_n, 1);
        chk("rel_busy", busy, 0);
        chk("rel_ready", op_ready, 0);

        ops[0] = 16'h0001; ops[1] = 16'h0002; ops[2] = 16'h0004;
        frame(3, 0, 1'b0, 1'b0, 0);
        chk("sum_1_2_4", acc_out, 16'h0007);

        ops[0] = 16'h8000; ops[1] = 16'h8000;
        frame(2, 2, 1'b1, 1'b1, 0);
        chk("ovf_hold", ovf, OVF_ON);

        frame(0, 0, 1'b0, 1'b0, 0);
        chk("sum_len0", acc_out, 16'h0000);
        chk("ovf_len0", ovf, 0);

        ops[0] = 16'h0011; ops[1] = 16'h0022; ops[2] = 16'h0033; ops[3] = 16'h0044;
        frame(4, 0, 1'b0, 1'b0, 2);
        ops[0] = 16'h00FF;
        frame(1, 0, 1'b0, 1'b0, 0);
        chk("sum_after_abort", acc_out, 16'h00FF);

        for (int i = 0; i < 8; i++) begin
            int n;
            n = int'($urandom_range(1, 6));
            for (int j = 0; j < 8; j++) ops[j] = W'($urandom);
            frame(n, -1, 1'b1, 1'b1, 0);
        end

        chk("load_q_empty", load_q.size(), 0);
        chk("frame_q_empty", frame_q.size(), 0);
        chk("clr_q_empty", clr_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
